// File: rtl/data_bus_queue_pkg.sv
// data_bus_pkg -- shared definitions for the data bus queue.
//   DATA_W_DEF / DEPTH_DEF : default data width and queue depth
//   cnt_w()                : width of an occupancy counter able to hold 0..depth
//   err_t                  : sticky error flag pair (overrun, underrun)
package data_bus_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;

    // A queue of `depth` entries needs one extra bit to represent "full".
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic overrun;
        logic underrun;
    } err_t;

endpackage

// File: rtl/data_bus_queue_if.sv
// data_bus_queue_if -- core-side handshakes plus external bus signals of the
// data bus queue.
//   slave  : the queue itself (receives bus/core requests, drives status)
//   master : the environment (CPU bus, core, pads)
// Signals: be, phi2, rwb, data_in, data_out, data_oe, wr_valid/wr_ready/wr_data,
//          rd_valid/rd_ready/rd_data, wr_count, rd_count, overrun, underrun, clr_err
interface data_bus_queue_if
    import data_bus_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
);
    localparam int CW = cnt_w(DEPTH);

    logic              be;
    logic              phi2;
    logic              rwb;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [CW-1:0]     wr_count;
    logic [CW-1:0]     rd_count;
    logic              overrun;
    logic              underrun;
    logic              clr_err;

    modport slave (
        input  be, phi2, rwb, data_in, wr_valid, wr_data, rd_ready, clr_err,
        output data_out, data_oe, wr_ready, rd_valid, rd_data,
               wr_count, rd_count, overrun, underrun
    );

    modport master (
        output be, phi2, rwb, data_in, wr_valid, wr_data, rd_ready, clr_err,
        input  data_out, data_oe, wr_ready, rd_valid, rd_data,
               wr_count, rd_count, overrun, underrun
    );

endinterface

// File: rtl/data_bus_queue_sync_fifo.sv
// sync_fifo -- first-word fall-through queue of DEPTH entries.
//   clk, rst      : clock, asynchronous active-high reset
//   push, din     : enqueue request (ignored while full)
//   pop           : dequeue request (ignored while empty)
//   head          : current head entry, valid whenever !empty
//   count         : occupancy 0..DEPTH
//   full, empty   : derived from the registered count
module sync_fifo
    import data_bus_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [DATA_W-1:0]         din,
    input  logic                      pop,
    output logic [DATA_W-1:0]         head,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      full,
    output logic                      empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = count_q;
    // Asynchronous read gives the zero-latency head the core side relies on.
    assign head    = mem_q[rd_ptr_q];

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH is implicit.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; pointers/count define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/data_bus_queue.sv
// data_bus_queue -- decouples a core from a phi2-timed external data bus with
// a write queue (core -> bus) and a read queue (bus -> core).
//   fclk  : system clock (phi2 is synchronous to it)
//   reset : asynchronous active-high reset
//   bus   : data_bus_queue_if.slave carrying the bus, handshakes, counts, flags
// A bus cycle ends on the falling edge of phi2. At that point a write cycle
// pops the write queue and a read cycle captures data_in into the read queue.
module data_bus_queue
    import data_bus_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                fclk,
    input  logic                reset,
    data_bus_queue_if.slave     bus
);
    localparam int CW = cnt_w(DEPTH);

    logic              phi2_q;
    logic              cyc_end;
    logic              wr_cyc_end;
    logic              rd_cyc_end;
    logic [DATA_W-1:0] last_pop_q, last_pop_d;
    err_t              err_q, err_d;

    logic              wq_push, wq_pop, wq_full, wq_empty;
    logic [DATA_W-1:0] wq_head;
    logic [CW-1:0]     wq_count;
    logic              rq_push, rq_pop, rq_full, rq_empty;
    logic [DATA_W-1:0] rq_head;
    logic [CW-1:0]     rq_count;
    logic              underrun_ev;
    logic              overrun_ev;

    // ---- phi2 falling-edge detect ----
    assign cyc_end    = phi2_q & ~bus.phi2;
    assign wr_cyc_end = cyc_end & bus.be & ~bus.rwb;
    assign rd_cyc_end = cyc_end & bus.be & bus.rwb;

    // ---- bus steering ----
    assign wq_push     = bus.wr_valid & ~wq_full;
    assign wq_pop      = wr_cyc_end & ~wq_empty;
    assign underrun_ev = wr_cyc_end & wq_empty;

    // Full is judged on the registered count, so a same-cycle core pop does
    // not make room for the capture.
    assign rq_push     = rd_cyc_end & ~rq_full;
    assign overrun_ev  = rd_cyc_end & rq_full;
    assign rq_pop      = bus.rd_ready & ~rq_empty;

    assign bus.wr_ready = ~wq_full;
    assign bus.rd_valid = ~rq_empty;
    assign bus.rd_data  = rq_head;
    assign bus.wr_count = wq_count;
    assign bus.rd_count = rq_count;
    assign bus.data_oe  = bus.be & ~bus.rwb & bus.phi2;

    // An empty write queue keeps driving the last value that left it.
    always_comb begin
        bus.data_out = '0;
        if (bus.data_oe) begin
            bus.data_out = wq_empty ? last_pop_q : wq_head;
        end
    end

    // ---- flags and last-popped value ----
    always_comb begin
        last_pop_d = last_pop_q;
        err_d      = err_q;
        if (wq_pop) begin
            last_pop_d = wq_head;
        end
        if (bus.clr_err) begin
            err_d = '0;
        end
        // Set events are applied after the clear so they take priority.
        if (underrun_ev) begin
            err_d.underrun = 1'b1;
        end
        if (overrun_ev) begin
            err_d.overrun = 1'b1;
        end
    end

    assign bus.overrun  = err_q.overrun;
    assign bus.underrun = err_q.underrun;

    always_ff @(posedge fclk or posedge reset) begin
        if (reset) begin
            phi2_q     <= 1'b0;
            last_pop_q <= '0;
            err_q      <= '0;
        end else begin
            phi2_q     <= bus.phi2;
            last_pop_q <= last_pop_d;
            err_q      <= err_d;
        end
    end

    // ---- queues ----
    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_wr_fifo (
        .clk   (fclk),
        .rst   (reset),
        .push  (wq_push),
        .din   (bus.wr_data),
        .pop   (wq_pop),
        .head  (wq_head),
        .count (wq_count),
        .full  (wq_full),
        .empty (wq_empty)
    );

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rd_fifo (
        .clk   (fclk),
        .rst   (reset),
        .push  (rq_push),
        .din   (bus.data_in),
        .pop   (rq_pop),
        .head  (rq_head),
        .count (rq_count),
        .full  (rq_full),
        .empty (rq_empty)
    );

endmodule

// File: tb/tb_data_bus_queue.sv
// tb_data_bus_queue -- directed scenarios plus randomized traffic for
// data_bus_queue, checked against a queue-based reference model.
module tb_data_bus_queue;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic fclk;
    logic reset;

    data_bus_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    data_bus_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .fclk  (fclk),
        .reset (reset),
        .bus   (bus)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DATA_W-1:0] m_wq[$];
    logic [DATA_W-1:0] m_rq[$];
    logic [DATA_W-1:0] m_last;
    bit                m_ovr;
    bit                m_unr;
    bit                m_phi_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_wq.delete();
        m_rq.delete();
        m_last     = '0;
        m_ovr      = 1'b0;
        m_unr      = 1'b0;
        m_phi_prev = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [DATA_W-1:0] exp_out;
        exp_out = '0;
        if (bus.be && !bus.rwb && bus.phi2) begin
            exp_out = (m_wq.size() != 0) ? m_wq[0] : m_last;
        end
        check({tag, ".wr_count"}, 32'(bus.wr_count), 32'(m_wq.size()));
        check({tag, ".rd_count"}, 32'(bus.rd_count), 32'(m_rq.size()));
        check({tag, ".wr_ready"}, 32'(bus.wr_ready), 32'(m_wq.size() != DEPTH));
        check({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(m_rq.size() != 0));
        if (m_rq.size() != 0) begin
            check({tag, ".rd_data"}, 32'(bus.rd_data), 32'(m_rq[0]));
        end
        check({tag, ".data_oe"}, 32'(bus.data_oe), 32'(bus.be && !bus.rwb && bus.phi2));
        check({tag, ".data_out"}, 32'(bus.data_out), 32'(exp_out));
        check({tag, ".overrun"}, 32'(bus.overrun), 32'(m_ovr));
        check({tag, ".underrun"}, 32'(bus.underrun), 32'(m_unr));
    endtask

    // Advance one fclk edge: evaluate the model on the inputs in force at the
    // edge, then compare shortly after the edge.
    task automatic step(input string tag = "step");
        bit cyc;
        bit wr_end;
        bit rd_end;
        bit wq_was_empty;
        bit rq_was_full;
        bit rq_was_empty;
        if (reset) begin
            model_reset();
        end else begin
            cyc          = m_phi_prev && !bus.phi2;
            wr_end       = cyc && bus.be && !bus.rwb;
            rd_end       = cyc && bus.be && bus.rwb;
            wq_was_empty = (m_wq.size() == 0);
            rq_was_full  = (m_rq.size() == DEPTH);
            rq_was_empty = (m_rq.size() == 0);
            if (wr_end && !wq_was_empty) m_last = m_wq.pop_front();
            if (bus.wr_valid && m_wq.size() + (wr_end && !wq_was_empty ? 1 : 0) < DEPTH)
                m_wq.push_back(bus.wr_data);
            if (bus.rd_ready && !rq_was_empty) void'(m_rq.pop_front());
            if (rd_end && !rq_was_full) m_rq.push_back(bus.data_in);
            if (bus.clr_err) begin
                m_ovr = 1'b0;
                m_unr = 1'b0;
            end
            if (wr_end && wq_was_empty) m_unr = 1'b1;
            if (rd_end && rq_was_full) m_ovr = 1'b1;
            m_phi_prev = bus.phi2;
        end
        @(posedge fclk);
        #1;
        check_all(tag);
    endtask

    // One phi2 bus cycle: `hi` edges high, then `lo` edges low; optional
    // core pop on the edge that ends the cycle.
    task automatic bus_cycle(input int hi, input int lo, input bit pop_at_end);
        bus.phi2 = 1'b1;
        repeat (hi) step("cyc_hi");
        bus.phi2     = 1'b0;
        bus.rd_ready = pop_at_end;
        step("cyc_end");
        bus.rd_ready = 1'b0;
        repeat (lo - 1) step("cyc_lo");
    endtask

    initial begin
        reset        = 1'b1;
        bus.be       = 1'b0;
        bus.phi2     = 1'b0;
        bus.rwb      = 1'b0;
        bus.data_in  = '0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        bus.clr_err  = 1'b0;
        model_reset();

        // Reset state
        repeat (3) step("reset");
        check("reset.wr_ready", 32'(bus.wr_ready), 32'd1);
        check("reset.data_out", 32'(bus.data_out), 32'd0);
        reset = 1'b0;
        step("release");

        // Two writes drained by two bus write cycles
        bus.be = 1'b1;
        bus.rwb = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_data = 8'h11;
        step("wpush");
        bus.wr_data = 8'h22;
        step("wpush");
        bus.wr_valid = 1'b0;
        check("w2.count", 32'(bus.wr_count), 32'd2);
        bus.phi2 = 1'b1;
        step("w1_hi");
        step("w1_hi");
        check("w1.data_out", 32'(bus.data_out), 32'h11);
        bus.phi2 = 1'b0;
        step("w1_end");
        check("w1.count", 32'(bus.wr_count), 32'd1);
        step("w1_lo");
        bus.phi2 = 1'b1;
        step("w2_hi");
        check("w2.data_out", 32'(bus.data_out), 32'h22);
        bus.phi2 = 1'b0;
        step("w2_end");
        check("w2.count_end", 32'(bus.wr_count), 32'd0);
        check("w2.underrun", 32'(bus.underrun), 32'd0);

        // Two captures, then core pops
        bus.rwb = 1'b1;
        bus.data_in = 8'hA5;
        bus_cycle(1, 1, 1'b0);
        bus.data_in = 8'h5A;
        bus_cycle(1, 2, 1'b0);
        check("r1.rd_data", 32'(bus.rd_data), 32'hA5);
        check("r1.rd_valid", 32'(bus.rd_valid), 32'd1);
        bus.rd_ready = 1'b1;
        step("rpop");
        bus.rd_ready = 1'b0;
        check("r2.rd_data", 32'(bus.rd_data), 32'h5A);
        bus.rd_ready = 1'b1;
        step("rpop");
        bus.rd_ready = 1'b0;

        // Fill read queue, then overflow while the core pops in the same cycle
        for (int i = 0; i < DEPTH; i++) begin
            bus.data_in = 8'($urandom);
            bus_cycle(1, 1, 1'b0);
        end
        check("full.rd_count", 32'(bus.rd_count), 32'(DEPTH));
        bus.data_in = 8'hEE;
        bus_cycle(1, 1, 1'b1);
        check("ovr.overrun", 32'(bus.overrun), 32'd1);
        check("ovr.rd_count", 32'(bus.rd_count), 32'(DEPTH - 1));

        // Write cycle with empty write queue: drives last popped value
        bus.rwb = 1'b0;
        bus.phi2 = 1'b1;
        step("unr_hi");
        check("unr.data_out", 32'(bus.data_out), 32'h22);
        bus.phi2 = 1'b0;
        step("unr_end");
        check("unr.underrun", 32'(bus.underrun), 32'd1);
        bus.clr_err = 1'b1;
        step("clr");
        bus.clr_err = 1'b0;
        check("clr.underrun", 32'(bus.underrun), 32'd0);

        // Bus disabled: loaded queues stay untouched
        bus.wr_valid = 1'b1;
        bus.wr_data = 8'h3C;
        step("wpush");
        bus.wr_data = 8'hC3;
        step("wpush");
        bus.wr_valid = 1'b0;
        bus.be = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.rwb = 1'(i);
            bus_cycle(2, 2, 1'b0);
        end
        check("idle.wr_count", 32'(bus.wr_count), 32'd2);
        check("idle.rd_count", 32'(bus.rd_count), 32'(DEPTH - 1));

        // Randomized traffic
        bus.be = 1'b1;
        for (int i = 0; i < 800; i++) begin
            bus.wr_valid = 1'($urandom_range(0, 1));
            bus.wr_data  = 8'($urandom);
            bus.rd_ready = ($urandom_range(0, 2) == 0);
            bus.data_in  = 8'($urandom);
            bus.be       = ($urandom_range(0, 7) != 0);
            bus.clr_err  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 2) == 0) bus.phi2 = ~bus.phi2;
            if (!bus.phi2 && $urandom_range(0, 1) == 0) bus.rwb = 1'($urandom_range(0, 1));
            step("rand");
        end
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        bus.clr_err  = 1'b0;
        bus.phi2     = 1'b0;
        step("settle");

        // Reset in the middle of a write cycle with three entries queued
        reset = 1'b1;
        step("pre_rst");
        reset = 1'b0;
        bus.be = 1'b0;
        bus.wr_valid = 1'b1;
        repeat (3) begin
            bus.wr_data = 8'($urandom);
            step("wpush");
        end
        bus.wr_valid = 1'b0;
        check("mid.wr_count", 32'(bus.wr_count), 32'd3);
        bus.be = 1'b1;
        bus.rwb = 1'b0;
        bus.phi2 = 1'b1;
        step("mid_hi");
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check("async.wr_count", 32'(bus.wr_count), 32'd0);
        check("async.rd_count", 32'(bus.rd_count), 32'd0);
        check("async.wr_ready", 32'(bus.wr_ready), 32'd1);
        check("async.rd_valid", 32'(bus.rd_valid), 32'd0);
        check("async.data_out", 32'(bus.data_out), 32'd0);
        check("async.data_oe", 32'(bus.data_oe), 32'd1);
        step("in_rst");
        bus.phi2 = 1'b0;
        step("in_rst");
        reset = 1'b0;
        repeat (3) step("post_rst");
        check("post.wr_count", 32'(bus.wr_count), 32'd0);
        check("post.underrun", 32'(bus.underrun), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_bus_queue.md
DATA_BUS_QUEUE -- requirements
Module: data_bus_queue

Interface
REQ-001 Parameter DATA_W, default 8, width of every data path.
REQ-002 Parameter DEPTH, default 4, entries per queue; power of two, >=2.
REQ-003 fclk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 be  in  1  bus enable; low = external bus idle, no capture, no drive.
REQ-006 phi2  in  1  CPU phase-2 clock, synchronous to fclk; bus cycle ends on its falling edge.
REQ-007 rwb  in  1  1 = external read cycle, 0 = external write cycle.
REQ-008 wr_valid / wr_ready / wr_data  in / out / DATA_W  core-side write-queue push handshake.
REQ-009 rd_valid / rd_ready / rd_data  out / in / DATA_W  core-side read-queue pop handshake.
REQ-010 data_in  in  DATA_W  external data bus, read direction.
REQ-011 data_out / data_oe  out / out  DATA_W / 1  external drive value and enable; a top-level pad applies tri-state.
REQ-012 wr_count / rd_count  out  $clog2(DEPTH)+1  current occupancy of each queue.
REQ-013 overrun / underrun  out  1  sticky error flags.
REQ-014 clr_err  in  1  synchronous clear of both sticky flags.

Function
REQ-015 phi2_q SHALL hold phi2 registered on fclk; the bus-cycle end strobe is cyc_end = phi2_q & ~phi2.
REQ-016 Write-queue push SHALL occur when wr_valid & wr_ready; wr_ready = (wr_count != DEPTH), evaluated from registered count only.
REQ-017 data_oe SHALL equal be & ~rwb & phi2, combinationally.
REQ-018 data_out SHALL equal the write-queue head when data_oe = 1 and the queue is not empty, hold the last popped value when data_oe = 1 and the queue is empty, and be all-zero when data_oe = 0.
REQ-019 On cyc_end with be & ~rwb, the write queue SHALL pop one entry.
REQ-020 If the write queue is empty on that cyc_end, it SHALL NOT pop, and underrun SHALL set.
REQ-021 On cyc_end with be & rwb, data_in SHALL be pushed into the read queue if rd_count != DEPTH.
REQ-022 If the read queue is full on that cyc_end, data_in SHALL be dropped and overrun SHALL set, even if a core pop occurs in the same cycle.
REQ-023 Read-queue pop SHALL occur when rd_valid & rd_ready; rd_valid = (rd_count != 0); rd_data = head, zero-latency (first-word fall-through).
REQ-024 A pushed entry SHALL be visible at the queue head on the next fclk edge (1-cycle latency).
REQ-025 Simultaneous push and pop on a queue SHALL leave its count unchanged and both operations SHALL take effect.
REQ-026 Pointers SHALL wrap modulo DEPTH, and counts SHALL range 0..DEPTH.
REQ-027 When be = 0, cyc_end SHALL be ignored: no pop, no capture, no flag change.
REQ-028 clr_err SHALL clear both flags; a set event in the same cycle as clr_err SHALL win.

Reset
REQ-029 reset SHALL asynchronously force pointers, counts, phi2_q, the last-popped register, overrun and underrun to 0.
REQ-030 During reset, wr_ready = 1, rd_valid = 0 and data_out = 0, with data_oe following REQ-017.
REQ-031 Reset mid-cycle SHALL discard all queued data, and no partial pop or capture SHALL occur on reset release.

Structure
REQ-032 Package data_bus_pkg SHALL hold the DATA_W/DEPTH defaults, a count-width constant function, and the err_t flag struct.
REQ-033 Both queues SHALL be instances of one sub-module, sync_fifo (parameters DATA_W and DEPTH; exposing push, pop, head, count, full and empty).
REQ-034 The top level SHALL contain only the phi2 edge detect, the bus steering and the flag logic.

Verification
REQ-035 Push 0x11, 0x22 with rwb = 0, be = 1, then 2 phi2 cycles -> data_out = 0x11 then 0x22 while phi2 is high, wr_count 2 -> 1 -> 0, no underrun.
REQ-036 With rwb = 1 and data_in = 0xA5, 0x5A over 2 phi2 cycles -> rd_data = 0xA5 with rd_valid = 1, then 0x5A after pop.
REQ-037 Fill the read queue (DEPTH = 4), then a 5th capture while popping the same cycle -> data dropped, overrun = 1, rd_count = 3.
REQ-038 Write cycle with the write queue empty -> underrun = 1 and data_out = last popped value; clr_err -> underrun = 0.
REQ-039 be = 0 across 3 phi2 cycles with both queues loaded -> counts unchanged and data_oe = 0.
REQ-040 Assert reset with wr_count = 3 mid-phi2 -> all counts 0 immediately, wr_ready = 1, and no pop on release.
